// File: rtl/cpm_pkg.sv
// rtl/cpm_pkg.sv - shared state encoding and saturation constant for clock_period_monitor
package cpm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT1,
    MEASURE,
    HOLD
  } cpm_state_e;

  // All-ones value of a cnt_w-bit counter; computed at 64 bits so cnt_w=32 does not overflow.
  function automatic logic [63:0] cpm_sat_value(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/clock_period_monitor_if.sv
// rtl/clock_period_monitor_if.sv - measurement result valid/ready channel
interface clock_period_monitor_if #(
  parameter int unsigned CNT_W = 16
);

  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  modport master (
    output meas_valid,
    output period,
    output high_time,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  period,
    input  high_time,
    output meas_ready
  );

endinterface

// File: rtl/cpm_sync_edge.sv
// rtl/cpm_sync_edge.sv - mon_clk synchronizer plus history flop producing rise/fall strobes
module cpm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mon_clk,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      hist_q <= sync_bit;
    end
  end

  assign rise = sync_bit & ~hist_q;
  assign fall = ~sync_bit & hist_q;

endmodule

// File: rtl/clock_period_monitor.sv
// rtl/clock_period_monitor.sv - measures period/high time of mon_clk in clk cycles; CPM_DUTY_CHECK_EN adds duty_err
module clock_period_monitor
  import cpm_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EXP_PERIOD  = 6,
  parameter int unsigned TOLERANCE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mon_clk,
  input  logic                   enable,
  input  logic                   clr_err,
  clock_period_monitor_if.master meas,
  output logic                   period_err,
  output logic                   overrun,
`ifdef CPM_DUTY_CHECK_EN
  output logic                   duty_err,
`endif
  output logic                   timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cpm_sat_value(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   EXP_EXT = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_EXT = (CNT_W+1)'(TOLERANCE);

  cpm_state_e       state_q, state_d;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt_q, hi_lat_q;
  logic             pend_q;
  logic [CNT_W-1:0] pend_period_q, pend_high_q;
  logic             valid_q;
  logic [CNT_W-1:0] period_q, high_q;

  logic             active, sat, accept, load, defer, drop;
  logic [CNT_W-1:0] load_period, load_high;
  logic [CNT_W:0]   p_ext, period_dev;
  logic             period_bad;

  cpm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .mon_clk (mon_clk),
    .rise    (rise),
    .fall    (fall)
  );

  assign meas.meas_valid = valid_q;
  assign meas.period     = period_q;
  assign meas.high_time  = high_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A rise that coincides with a completed handshake is deferred one cycle (defer/pend_q)
  // so the consumer never sees a result overwritten under an accepted beat.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    defer   = 1'b0;
    drop    = 1'b0;
    active  = (state_q == MEASURE) || (state_q == HOLD);
    sat     = active && !rise && (cnt_q == CNT_MAX);
    accept  = valid_q && meas.meas_ready;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = WAIT1;
        WAIT1: if (rise) state_d = MEASURE;
        MEASURE, HOLD: begin
          if (pend_q) begin
            load    = 1'b1;
            state_d = HOLD;
          end else if (rise) begin
            if (accept) begin
              defer   = 1'b1;
              state_d = MEASURE;
            end else if (valid_q) begin
              drop = 1'b1;
            end else begin
              load    = 1'b1;
              state_d = HOLD;
            end
          end else if (sat) begin
            state_d = WAIT1;
          end else if (accept && (state_q == HOLD)) begin
            state_d = MEASURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load_period = pend_q ? pend_period_q : cnt_q;
    load_high   = pend_q ? pend_high_q : hi_lat_q;
    p_ext       = {1'b0, load_period};
    period_dev  = (p_ext >= EXP_EXT) ? (p_ext - EXP_EXT) : (EXP_EXT - p_ext);
    period_bad  = period_dev > TOL_EXT;
  end

`ifdef CPM_DUTY_CHECK_EN
  localparam logic [CNT_W+1:0] DUTY_LIM = (CNT_W+2)'(2 * TOLERANCE + 1);
  logic [CNT_W+1:0] two_high, p2_ext, duty_dev;
  logic             duty_bad;

  always_comb begin
    two_high = {1'b0, load_high, 1'b0};
    p2_ext   = {2'b00, load_period};
    duty_dev = (two_high >= p2_ext) ? (two_high - p2_ext) : (p2_ext - two_high);
    duty_bad = duty_dev > DUTY_LIM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty_err <= 1'b0;
    else     duty_err <= (load && duty_bad) || (duty_err && !clr_err);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      hi_lat_q      <= '0;
      pend_q        <= 1'b0;
      pend_period_q <= '0;
      pend_high_q   <= '0;
      valid_q       <= 1'b0;
      period_q      <= '0;
      high_q        <= '0;
      period_err    <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      if (rise)                             cnt_q <= CNT_ONE;
      else if (active && cnt_q != CNT_MAX)  cnt_q <= cnt_q + CNT_ONE;

      if (active && fall) hi_lat_q <= cnt_q;

      pend_q <= defer;
      if (defer) begin
        pend_period_q <= cnt_q;
        pend_high_q   <= hi_lat_q;
      end

      if (!enable)     valid_q <= 1'b0;
      else if (load)   valid_q <= 1'b1;
      else if (accept) valid_q <= 1'b0;

      if (load) begin
        period_q <= load_period;
        high_q   <= load_high;
      end

      // Sticky flags: a set in the same cycle as clr_err wins.
      period_err <= (load && period_bad) || (period_err && !clr_err);
      overrun    <= drop || (overrun && !clr_err);
      timeout    <= (enable && sat) || (timeout && !clr_err);
    end
  end

endmodule
